// File: rtl/uart_tx.sv
// uart_tx: drains the TX fifo one word per frame (start, DataBits LSB-first, [parity], StopBits); parity bit only when UART_TX_PARITY_EN is defined.
// Latency: pop -> start bit on tx_o 2 edges later; tx_en_i low lets the current frame finish, then no further pops.
module uart_tx #(
    parameter int ClksPerBit = 868,
    parameter int DataBits   = 8,
    parameter int StopBits   = 1,
    parameter int ParityOdd  = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tx_en_i,
    input  logic                fifo_empty_i,
    input  logic [DataBits-1:0] fifo_rd_data_i,
    output logic                fifo_rd_en_o,
    output logic                tx_o,
    output logic                busy_o
);

    localparam int BaudW = $clog2(ClksPerBit);
    localparam int BitW  = $clog2(DataBits);

    if (ClksPerBit < 2) begin : g_bad_clks
        $error("uart_tx: ClksPerBit must be >= 2");
    end
    if (DataBits < 5 || DataBits > 8) begin : g_bad_data
        $error("uart_tx: DataBits must be 5..8");
    end
    if (StopBits < 1 || StopBits > 2) begin : g_bad_stop
        $error("uart_tx: StopBits must be 1 or 2");
    end
    if (ParityOdd != 0 && ParityOdd != 1) begin : g_bad_par
        $error("uart_tx: ParityOdd must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e              state_q, state_d;
    logic [BaudW-1:0]    baud_q, baud_d;
    logic [BitW-1:0]     bit_q, bit_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                bit_end;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    assign fifo_rd_en_o = (state_q == IDLE) && tx_en_i && !fifo_empty_i && !rst_i;
    assign bit_end      = (baud_q == BaudW'(ClksPerBit - 1));
    assign tx_o         = tx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (fifo_rd_en_o) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                shift_d = fifo_rd_data_i;
                baud_d  = '0;
                bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                par_d   = (^fifo_rd_data_i) ^ (ParityOdd != 0);
`endif
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BitW'(DataBits - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
`endif
            STOP: begin
                // bit_cnt is reused to count stop bits
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == BitW'(StopBits - 1)) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx is derived from the next state so the line changes on the same edge as the state
    always_comb begin
        busy_o = (state_q != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at ClksPerBit=4: main instance with StopBits=1, second instance with StopBits=2.
module tb_uart_tx;

    localparam int CPB     = 4;
    localparam bit PAR_ODD = 1'b0;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       tx_en  = 1'b0;
    logic       tx_en2 = 1'b0;
    logic       empty2 = 1'b1;
    logic [7:0] data2  = 8'h55;
    logic [7:0] rd_data = 8'h00;
    logic       fifo_empty, rd_en, tx, busy;
    logic       rd_en2, tx2, busy2;

    logic [7:0] mem [16];
    int head = 0, tail = 0, pops = 0, pops2 = 0;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (head == tail);

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[head % 16];
            head    <= head + 1;
            pops    <= pops + 1;
        end
        if (rd_en2) pops2 <= pops2 + 1;
    end

    uart_tx #(.ClksPerBit(CPB), .DataBits(8), .StopBits(1), .ParityOdd(PAR_ODD)) dut (
        .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en), .fifo_empty_i(fifo_empty),
        .fifo_rd_data_i(rd_data), .fifo_rd_en_o(rd_en), .tx_o(tx), .busy_o(busy)
    );

    uart_tx #(.ClksPerBit(CPB), .DataBits(8), .StopBits(2), .ParityOdd(PAR_ODD)) dut2 (
        .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en2), .fifo_empty_i(empty2),
        .fifo_rd_data_i(data2), .fifo_rd_en_o(rd_en2), .tx_o(tx2), .busy_o(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[tail % 16] = d;
        tail++;
    endtask

    // Called at a negedge in IDLE with a word available; returns at the negedge of the first START cycle.
    task automatic start_seq(input string tag);
        chk({tag, " idle tx"}, tx, 1);
        #1 chk({tag, " rd_en"}, rd_en, 1);
        @(negedge clk);
        chk({tag, " fetch tx"}, tx, 1);
        chk({tag, " fetch rd_en"}, rd_en, 0);
        chk({tag, " fetch busy"}, busy, 1);
        @(negedge clk);
    endtask

    // Checks every cycle of a frame; drop_at >= 0 deasserts tx_en at that cycle index.
    task automatic check_frame(input string tag, input bit sel, input logic [7:0] d,
                               input int nstop, input int drop_at);
        logic [15:0] bits;
        int nb;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nb = 9;
`ifdef UART_TX_PARITY_EN
        bits[9] = (^d) ^ PAR_ODD;
        nb = 10;
`endif
        nb = nb + nstop;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b * CPB + c == drop_at) tx_en = 1'b0;
                chk($sformatf("%s bit%0d cyc%0d", tag, b, c), sel ? tx2 : tx, bits[b]);
                if (b == nb - 1 && c == CPB - 1)
                    chk({tag, " busy last stop"}, sel ? busy2 : busy, 1);
                @(negedge clk);
            end
        end
        chk({tag, " busy after"}, sel ? busy2 : busy, 0);
    endtask

    initial begin
        int p0;
        int bad;

        // reset state, pop gated by reset
        @(negedge clk);
        @(negedge clk);
        chk("rst tx", tx, 1);
        chk("rst busy", busy, 0);
        chk("rst rd_en", rd_en, 0);
        chk("rst tx2", tx2, 1);
        push(8'hA5);
        tx_en = 1'b1;
        #1 chk("rst rd_en gated", rd_en, 0);
        @(negedge clk);
        rst = 1'b0;

        // single word 0xA5
        p0 = pops;
        start_seq("a5");
        check_frame("a5", 1'b0, 8'hA5, 1, -1);
        chk("a5 pops", pops - p0, 1);

`ifdef UART_TX_PARITY_EN
        push(8'h07);
        start_seq("07");
        check_frame("07", 1'b0, 8'h07, 1, -1);
`endif

        // back-to-back: 2-cycle high gap between stop and next start
        p0 = pops;
        push(8'h00);
        push(8'hFF);
        start_seq("b2b0");
        check_frame("b2b0", 1'b0, 8'h00, 1, -1);
        start_seq("b2b1");
        check_frame("b2b1", 1'b0, 8'hFF, 1, -1);
        #1 chk("b2b rd_en after", rd_en, 0);
        chk("b2b pops", pops - p0, 2);

        // empty fifo for 100 cycles
        p0 = pops;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("empty anomalies", bad, 0);
        chk("empty pops", pops - p0, 0);

        // tx_en dropped during data bit 3 of 0x3C
        p0 = pops;
        push(8'h3C);
        push(8'h81);
        start_seq("3c");
        check_frame("3c", 1'b0, 8'h3C, 1, 4 * CPB);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("txen off anomalies", bad, 0);
        chk("txen off pops", pops - p0, 1);
        tx_en = 1'b1;
        start_seq("81");
        check_frame("81", 1'b0, 8'h81, 1, -1);
        chk("81 pops", pops - p0, 2);

        // reset in the middle of a data bit that is low
        push(8'hF0);
        start_seq("f0");
        for (int i = 0; i < CPB + 2; i++) @(negedge clk);
        chk("f0 pre-rst tx", tx, 0);
        chk("f0 pre-rst busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst tx", tx, 1);
        chk("midrst busy", busy, 0);
        chk("midrst rd_en", rd_en, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst tx", tx, 1);
        chk("postrst busy", busy, 0);
        push(8'h5A);
        start_seq("5a");
        check_frame("5a", 1'b0, 8'h5A, 1, -1);

        // two stop bits on the second instance
        empty2 = 1'b0;
        tx_en2 = 1'b1;
        #1 chk("sb2 rd_en", rd_en2, 1);
        @(negedge clk);
        tx_en2 = 1'b0;
        empty2 = 1'b1;
        chk("sb2 fetch tx", tx2, 1);
        chk("sb2 fetch busy", busy2, 1);
        @(negedge clk);
        check_frame("sb2", 1'b1, 8'h55, 2, -1);
        chk("sb2 pops", pops2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
